// File: rtl/icache_pkg.sv
// Shared sizes and FSM state type for the instruction-cache refill path.
package icache_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int INST_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  // Byte offset inside one instruction word; the cache tag/index split uses it too.
  localparam int OFS_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FILL,
    ERR
  } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch, cache-fill and instruction-memory signals of the refill controller.
interface icache_refill_ctrl_if
  import icache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic [ADDR_W-1:0] PcIn;
  logic              FetchValid;
  logic              CacheMissing;
  logic              FlushReq;
  logic              MemArValid;
  logic              MemArReady;
  logic [ADDR_W-1:0] MemArAddr;
  logic              MemRValid;
  logic              MemRReady;
  logic [INST_W-1:0] MemRData;
  logic              MemRErr;
  logic              FillValid;
  logic [ADDR_W-1:0] FillAddr;
  logic [INST_W-1:0] FillData;
  logic              FetchStall;
  logic              FetchErr;
  logic [CNT_W-1:0]  MissCount;

  modport master (
    input  PcIn, FetchValid, CacheMissing, FlushReq,
    input  MemArReady, MemRValid, MemRData, MemRErr,
    output MemArValid, MemArAddr, MemRReady,
    output FillValid, FillAddr, FillData,
    output FetchStall, FetchErr, MissCount
  );

  modport slave (
    output PcIn, FetchValid, CacheMissing, FlushReq,
    output MemArReady, MemRValid, MemRData, MemRErr,
    input  MemArValid, MemArAddr, MemRReady,
    input  FillValid, FillAddr, FillData,
    input  FetchStall, FetchErr, MissCount
  );

endinterface

// File: rtl/icache_miss_counter.sv
// Saturating event counter used for the refill performance monitor.
module icache_miss_counter
  import icache_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Blocking single-word refill controller for the direct-mapped I-cache.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic                  Clk,
  input logic                  Rst,
  icache_refill_ctrl_if.master bus
);

  refill_state_e     state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [INST_W-1:0] fill_data_q, fill_data_d;
  logic              cancel_q, cancel_d;
  logic              miss_inc;
  logic              miss_req;
  logic              unused_ofs;

  assign miss_req   = bus.FetchValid && bus.CacheMissing;
  assign unused_ofs = ^bus.PcIn[OFS_W-1:0];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      cancel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
      cancel_q    <= cancel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    cancel_d    = cancel_q;
    miss_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_req && !bus.FlushReq) begin
          miss_addr_d = {bus.PcIn[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
          cancel_d    = 1'b0;
          miss_inc    = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        // The AR beat stays up after a flush; only its response is dropped.
        if (bus.FlushReq) cancel_d = 1'b1;
        if (bus.MemArReady) state_d = WAIT;
      end
      WAIT: begin
        if (bus.FlushReq) cancel_d = 1'b1;
        if (bus.MemRValid) begin
          if (cancel_q || bus.FlushReq) begin
            state_d = IDLE;
          end else if (bus.MemRErr) begin
            state_d = ERR;
          end else begin
            fill_addr_d = miss_addr_q;
            fill_data_d = bus.MemRData;
            state_d     = FILL;
          end
        end
      end
      FILL: state_d = IDLE;
      ERR: begin
        if (bus.FlushReq) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.MemArValid = (state_q == REQ);
  assign bus.MemArAddr  = miss_addr_q;
  assign bus.MemRReady  = (state_q == WAIT);
  assign bus.FillValid  = (state_q == FILL);
  assign bus.FillAddr   = fill_addr_q;
  assign bus.FillData   = fill_data_q;
  assign bus.FetchErr   = (state_q == ERR);
  assign bus.FetchStall = (state_q != IDLE) || miss_req;

  icache_miss_counter #(
    .CNT_W (CNT_W)
  ) u_miss_cnt (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .inc_i   (miss_inc),
    .count_o (bus.MissCount)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench for icache_refill_ctrl.
module tb_icache_refill_ctrl;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam int CW = 4;

  localparam int M_NORM  = 0;
  localparam int M_FLREQ = 1;
  localparam int M_FLR   = 2;
  localparam int M_ERR   = 3;

  typedef struct {
    int          done_cyc;
    int          arhs;
    int          rbeats;
    int          fills;
    int          fill_cyc;
    int          beat_cyc;
    int          err_cycles;
    int          first_err_cyc;
    bit          ar_seen;
    bit          ar_stable;
    bit          err_at_done;
    logic [AW-1:0] ar_addr;
    logic [AW-1:0] faddr;
    logic [IW-1:0] fdata;
  } res_t;

  logic Clk = 1'b0;
  logic Rst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_cnt = 0;

  always #5 Clk = ~Clk;

  icache_refill_ctrl_if #(.ADDR_W(AW), .INST_W(IW), .CNT_W(CW)) bus ();

  icache_refill_ctrl #(
    .ADDR_W (AW),
    .INST_W (IW),
    .CNT_W  (CW)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic idle_inputs();
    bus.PcIn         = '0;
    bus.FetchValid   = 1'b0;
    bus.CacheMissing = 1'b0;
    bus.FlushReq     = 1'b0;
    bus.MemArReady   = 1'b0;
    bus.MemRValid    = 1'b0;
    bus.MemRData     = '0;
    bus.MemRErr      = 1'b0;
  endtask

  // Drives one miss through a simple memory responder and records what the DUT did.
  task automatic run_miss(input logic [AW-1:0] pc, input logic [IW-1:0] data,
                          input int ar_dly, input int r_dly, input int mode,
                          input int hold, output res_t r);
    int cyc, ar_wait, r_wait;
    bit ar_done, r_pend, done, fill_seen, flushed;
    r = '{done_cyc: -1, fill_cyc: -1, beat_cyc: -1, first_err_cyc: -1,
          ar_stable: 1'b1, default: 0};
    cyc = 0; ar_wait = 0; r_wait = 0;
    ar_done = 0; r_pend = 0; done = 0; fill_seen = 0; flushed = 0;
    @(posedge Clk); #1;
    idle_inputs();
    bus.PcIn = pc;
    bus.FetchValid = 1'b1;
    bus.CacheMissing = 1'b1;
    model_cnt = sat_inc(model_cnt);
    while (!done && cyc < 300) begin
      @(negedge Clk);
      if (cyc >= 1 && !ar_done && !bus.MemArValid) r.ar_stable = 1'b0;
      if (bus.MemArValid) begin
        if (ar_done) r.arhs++;
        if (!r.ar_seen) begin
          r.ar_seen = 1'b1;
          r.ar_addr = bus.MemArAddr;
        end else if (bus.MemArAddr !== r.ar_addr) begin
          r.ar_stable = 1'b0;
        end
        if (bus.MemArReady && !ar_done) begin
          r.arhs++; ar_done = 1; r_pend = 1; r_wait = 0;
        end
      end
      if (bus.MemRValid && bus.MemRReady) begin
        r.rbeats++; r.beat_cyc = cyc; r_pend = 0;
      end
      if (bus.FillValid) begin
        r.fills++; r.fill_cyc = cyc; fill_seen = 1;
        r.faddr = bus.FillAddr; r.fdata = bus.FillData;
      end
      if (bus.FetchErr && bus.FetchStall) begin
        r.err_cycles++;
        if (r.first_err_cyc < 0) r.first_err_cyc = cyc;
      end
      if (!bus.FetchStall && cyc > 0) begin
        done = 1; r.done_cyc = cyc; r.err_at_done = bus.FetchErr;
      end
      @(posedge Clk); #1;
      cyc++;
      bus.FlushReq = 1'b0;
      if (fill_seen) bus.CacheMissing = 1'b0;
      bus.MemArReady = 1'b0;
      if (bus.MemArValid && !ar_done) begin
        bus.MemArReady = (ar_wait >= ar_dly);
        ar_wait++;
      end
      bus.MemRValid = 1'b0;
      bus.MemRErr = 1'b0;
      if (r_pend) begin
        if (r_wait >= r_dly) begin
          bus.MemRValid = 1'b1;
          bus.MemRData = data;
          bus.MemRErr = (mode == M_ERR);
        end
        r_wait++;
      end
      if (mode == M_FLREQ && cyc == 1) begin
        bus.FlushReq = 1'b1; bus.FetchValid = 1'b0;
      end
      if (mode == M_FLR && bus.MemRValid && !flushed) begin
        bus.FlushReq = 1'b1; bus.FetchValid = 1'b0; flushed = 1;
      end
      if (mode == M_ERR && r.beat_cyc >= 0 && cyc == r.beat_cyc + 1 + hold) begin
        bus.FlushReq = 1'b1; bus.FetchValid = 1'b0;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    @(posedge Clk); #1;
    idle_inputs();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_chk++;
    if ({bus.MemArValid, bus.MemRReady, bus.FillValid, bus.FetchErr, bus.FetchStall} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 00000",
               {bus.MemArValid, bus.MemRReady, bus.FillValid, bus.FetchErr, bus.FetchStall});
    end
    n_chk++;
    if ({bus.MemArAddr, bus.FillAddr, bus.FillData} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h expected 0", bus.MemArAddr, bus.FillAddr, bus.FillData);
    end
    n_chk++;
    if (bus.MissCount !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h expected 0", bus.MissCount);
    end
    bus.FetchValid = 1'b1;
    bus.CacheMissing = 1'b1;
    #1;
    n_chk++;
    if (bus.FetchStall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_eq: got %b expected 1", bus.FetchStall);
    end
    idle_inputs();
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_basic();
    res_t r;
    run_miss(64'h8000_0010, 32'h0000_0013, 0, 0, M_NORM, 0, r);
    n_chk++;
    if (r.ar_addr !== 64'h8000_0010) begin
      n_fail++; $display("FAIL basic_araddr: got %h expected 80000010", r.ar_addr);
    end
    n_chk++;
    if (r.fill_cyc !== 3 || r.fills !== 1) begin
      n_fail++; $display("FAIL basic_fill_cyc: got %0d/%0d expected 3/1", r.fill_cyc, r.fills);
    end
    n_chk++;
    if (r.faddr !== 64'h8000_0010 || r.fdata !== 32'h13) begin
      n_fail++; $display("FAIL basic_fill: got %h %h expected 80000010 13", r.faddr, r.fdata);
    end
    n_chk++;
    if (r.done_cyc !== 4) begin
      n_fail++; $display("FAIL basic_penalty: got %0d expected 4", r.done_cyc);
    end
    n_chk++;
    if (bus.MissCount !== CW'(model_cnt)) begin
      n_fail++; $display("FAIL basic_cnt: got %0d expected %0d", bus.MissCount, model_cnt);
    end
  endtask

  task automatic test_backpressure();
    res_t r;
    logic [AW-1:0] pc;
    pc = {$urandom(), $urandom()};
    run_miss(pc, 32'hdead_beef, 3, 5, M_NORM, 0, r);
    n_chk++;
    if (!r.ar_stable || r.ar_addr !== (pc & ~64'h3)) begin
      n_fail++; $display("FAIL bp_ar_stable: got %b %h expected 1 %h", r.ar_stable, r.ar_addr, pc & ~64'h3);
    end
    n_chk++;
    if (r.arhs !== 1) begin
      n_fail++; $display("FAIL bp_ar_count: got %0d expected 1", r.arhs);
    end
    n_chk++;
    if (r.done_cyc !== 12) begin
      n_fail++; $display("FAIL bp_penalty: got %0d expected 12", r.done_cyc);
    end
    n_chk++;
    if (r.fdata !== 32'hdead_beef || r.faddr !== (pc & ~64'h3)) begin
      n_fail++; $display("FAIL bp_fill: got %h %h", r.faddr, r.fdata);
    end
  endtask

  task automatic test_flush_req();
    res_t r;
    int ar, rd;
    ar = $urandom_range(1, 4);
    rd = $urandom_range(0, 3);
    run_miss({$urandom(), $urandom()}, $urandom(), ar, rd, M_FLREQ, 0, r);
    n_chk++;
    if (r.arhs !== 1 || r.rbeats !== 1) begin
      n_fail++; $display("FAIL flreq_bus: got ar=%0d r=%0d expected 1 1", r.arhs, r.rbeats);
    end
    n_chk++;
    if (r.fills !== 0) begin
      n_fail++; $display("FAIL flreq_nofill: got %0d expected 0", r.fills);
    end
    n_chk++;
    if (r.done_cyc !== 3 + ar + rd) begin
      n_fail++; $display("FAIL flreq_idle: got %0d expected %0d", r.done_cyc, 3 + ar + rd);
    end
  endtask

  task automatic test_flush_r();
    res_t r;
    int ar, rd;
    ar = $urandom_range(0, 3);
    rd = $urandom_range(0, 3);
    run_miss({$urandom(), $urandom()}, $urandom(), ar, rd, M_FLR, 0, r);
    n_chk++;
    if (r.fills !== 0 || r.rbeats !== 1) begin
      n_fail++; $display("FAIL flr_nofill: got fills=%0d r=%0d expected 0 1", r.fills, r.rbeats);
    end
    n_chk++;
    if (r.done_cyc !== 3 + ar + rd) begin
      n_fail++; $display("FAIL flr_idle: got %0d expected %0d", r.done_cyc, 3 + ar + rd);
    end
  endtask

  task automatic test_error();
    res_t r;
    int ar, rd, beat;
    ar = $urandom_range(0, 3);
    rd = $urandom_range(0, 3);
    beat = 2 + ar + rd;
    run_miss({$urandom(), $urandom()}, $urandom(), ar, rd, M_ERR, 10, r);
    n_chk++;
    if (r.first_err_cyc !== beat + 1) begin
      n_fail++; $display("FAIL err_latency: got %0d expected %0d", r.first_err_cyc, beat + 1);
    end
    n_chk++;
    if (r.err_cycles !== 11) begin
      n_fail++; $display("FAIL err_hold: got %0d expected 11", r.err_cycles);
    end
    n_chk++;
    if (r.fills !== 0) begin
      n_fail++; $display("FAIL err_nofill: got %0d expected 0", r.fills);
    end
    n_chk++;
    if (r.done_cyc !== beat + 12 || r.err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL err_release: got %0d/%b expected %0d/0", r.done_cyc, r.err_at_done, beat + 12);
    end
    n_chk++;
    if (bus.MissCount !== CW'(model_cnt)) begin
      n_fail++; $display("FAIL err_cnt: got %0d expected %0d", bus.MissCount, model_cnt);
    end
  endtask

  task automatic test_saturation();
    res_t r;
    logic [AW-1:0] pc;
    logic [IW-1:0] d;
    int ar, rd;
    test_reset();
    for (int i = 0; i < 17; i++) begin
      pc = {$urandom(), $urandom()};
      d = $urandom();
      ar = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      run_miss(pc, d, ar, rd, M_NORM, 0, r);
      n_chk++;
      if (r.faddr !== (pc & ~64'h3) || r.fdata !== d || r.done_cyc !== 4 + ar + rd) begin
        n_fail++;
        $display("FAIL rand_miss%0d: got %h %h %0d expected %h %h %0d", i,
                 r.faddr, r.fdata, r.done_cyc, pc & ~64'h3, d, 4 + ar + rd);
      end
      n_chk++;
      if (bus.MissCount !== CW'(model_cnt)) begin
        n_fail++; $display("FAIL rand_cnt%0d: got %0d expected %0d", i, bus.MissCount, model_cnt);
      end
    end
    n_chk++;
    if (bus.MissCount !== 4'hF) begin
      n_fail++; $display("FAIL sat_cnt: got %h expected f", bus.MissCount);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge Clk); #1;
    idle_inputs();
    bus.PcIn = 64'h0000_0000_1234_5678;
    bus.FetchValid = 1'b1;
    bus.CacheMissing = 1'b1;
    @(posedge Clk); #1;
    bus.MemArReady = 1'b1;
    @(posedge Clk); #1;
    bus.MemArReady = 1'b0;
    @(negedge Clk);
    n_chk++;
    if (bus.MemRReady !== 1'b1) begin
      n_fail++; $display("FAIL mid_in_wait: got %b expected 1", bus.MemRReady);
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    bus.FetchValid = 1'b0;
    bus.CacheMissing = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_cnt = 0;
    @(negedge Clk);
    n_chk++;
    if ({bus.MemArValid, bus.MemRReady, bus.FillValid, bus.FetchErr, bus.FetchStall} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ctl: got %b expected 00000",
               {bus.MemArValid, bus.MemRReady, bus.FillValid, bus.FetchErr, bus.FetchStall});
    end
    n_chk++;
    if ({bus.MemArAddr, bus.FillAddr, bus.FillData} !== '0 || bus.MissCount !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_rst_data: got %h %h %h %h expected 0",
               bus.MemArAddr, bus.FillAddr, bus.FillData, bus.MissCount);
    end
  endtask

  initial begin
    Rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_req();
    test_flush_r();
    test_error();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Blocking refill controller for the direct-mapped instruction cache. It sits between the fetch stage, the cache, and the instruction-memory read port. On a fetch miss it stalls fetch, issues one single-word read, and writes the returned instruction into the cache through the cache's fill port. It also handles pipeline redirects that arrive mid-refill, memory error responses, and a saturating miss counter for performance monitoring.

## Interface
Clocking and reset: one clock; reset is synchronous and active-high.

Parameters:
- ADDR_W, 64, fetch/memory address width
- INST_W, 32, instruction/fill data width
- CNT_W, 32, miss counter width

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- PcIn  in  ADDR_W  current fetch PC, as presented to the cache read side
- FetchValid  in  1  fetch stage is requesting PcIn this cycle
- CacheMissing  in  1  cache miss indication for PcIn
- FlushReq  in  1  redirect or fence.i; cancels any in-flight refill
- MemArValid  out  1  read address valid
- MemArReady  in  1  read address accepted
- MemArAddr  out  ADDR_W  read address, word-aligned
- MemRValid  in  1  read data valid
- MemRReady  out  1  read data accepted
- MemRData  in  INST_W  read data
- MemRErr  in  1  read response error, qualified by MemRValid
- FillValid  out  1  cache write strobe (drives the cache's shake-hands input)
- FillAddr  out  ADDR_W  cache write address (drives the cache's pre-PC input)
- FillData  out  INST_W  cache write data
- FetchStall  out  1  fetch must hold its PC
- FetchErr  out  1  instruction access fault for the held PC
- MissCount  out  CNT_W  saturating count of refills started

## Operation
States: IDLE, REQ, WAIT, FILL, ERR.

- **IDLE**
  - If FetchValid && CacheMissing && !FlushReq: latch MissAddr = {PcIn[ADDR_W-1:2], 2'b00}, clear Cancel, increment MissCount, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - MemArValid=1 and MemArAddr=MissAddr, both held stable until MemArReady. On handshake go to WAIT.
  - The address request is never retracted, even on FlushReq.
- **WAIT**
  - MemRReady=1.
  - On MemRValid:
    - if Cancel, or FlushReq is high this cycle: discard the data, go to IDLE;
    - else if MemRErr: go to ERR;
    - else: register FillData=MemRData and FillAddr=MissAddr, go to FILL.
- **FILL**
  - FillValid=1 for exactly one cycle, then go to IDLE.
  - FlushReq in FILL does not suppress the write. The data is correct for FillAddr, so writing it is harmless.
- **ERR**
  - FetchErr=1 and FetchStall=1, held until FlushReq, then go to IDLE.
  - No fill is performed, so the faulting PC never hits.
- **Cancel flag**
  - Set by FlushReq in REQ or WAIT.
  - Cleared on entry to REQ.
- **Output rules**
  - FetchStall = (state!=IDLE) || (FetchValid && CacheMissing).
  - MemRReady = (state==WAIT), decoded combinationally from registered state.
  - MissCount saturates at all-ones and does not wrap.
- **Reset values**: state=IDLE, MissAddr=0, Cancel=0, MemArValid=0, MemArAddr=0, MemRReady=0, FillValid=0, FillAddr=0, FillData=0, FetchErr=0, MissCount=0. FetchStall then follows its equation from the inputs.
- **Reset mid-transaction**: the controller returns to IDLE. The memory side is reset in the same cycle, so no orphan response is expected.

## Timing
- Miss detected in cycle T0 (IDLE). MemArValid is registered high at T1.
- With MemArReady at T1 and MemRValid at T2, FillValid is high at T3. The cache writes at the end of T3, and PcIn hits at T4. Minimum miss penalty is 4 cycles.
- Each MemArReady stall cycle or MemRValid delay cycle adds exactly one cycle.
- At most one outstanding read; no second request until the controller is back in IDLE.
- FetchErr asserts the cycle after the erroring MemRValid.
- FlushReq in IDLE has no effect. FlushReq in ERR returns to IDLE on the next cycle.

## Structure
- Shared package icache_pkg holds:
  - the state enum (IDLE/REQ/WAIT/FILL/ERR);
  - ADDR_W, INST_W and CNT_W defaults;
  - the word-offset width localparam (2), shared with the cache tag/index split.
- One natural sub-module: icache_miss_counter, a saturating CNT_W-bit counter with increment enable. Everything else is a single FSM plus registers.

## Test plan
- **Basic miss/fill**: PcIn=0x8000_0010 missing, MemArReady=1 immediately, MemRData=0x0000_0013 one cycle later. Expect MemArAddr=0x8000_0010, FillValid at T3 with FillAddr=0x8000_0010 and FillData=0x13, FetchStall low at T4, MissCount=1.
- **Backpressure**: MemArReady low for 3 cycles, then MemRValid delayed 5 cycles. Expect MemArValid and MemArAddr stable throughout, a penalty of 4+3+5 cycles, and exactly one AR handshake.
- **Flush in REQ**: FlushReq pulse while MemArReady is low. Expect the AR still completes, the R beat is consumed, FillValid never asserts, and the controller is in IDLE after the R beat.
- **Flush coincident with MemRValid in WAIT**: data discarded, FillValid=0, next state IDLE.
- **Error response**: MemRErr=1 on the R beat. Expect FetchErr=1 and FetchStall=1 held 10 cycles with no fill; FlushReq then returns both to 0 in IDLE.
- **Counter saturation with reset mid-refill**: with CNT_W=4, 17 misses leave MissCount=4'hF. A reset asserted in WAIT clears all outputs to their reset values on the next cycle.
